// File: rtl/core_pkg.sv
// Shared RV32I decode types: opcodes, the decoded control word and scoreboard helpers.
// Imported by decode_stage and decode_scoreboard.
package core_pkg;

    localparam int unsigned CoreXlen = 32;
    localparam int unsigned RegW     = 5;

    typedef enum logic [6:0] {
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP     = 7'b0110011,
        OP_IMM = 7'b0010011,
        BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic {
        REG_OPERAND = 1'b0,
        IMEM        = 1'b1
    } op_mux_e;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_sel_t;

    typedef struct packed {
        logic [RegW-1:0] rs1_addr;
        logic [RegW-1:0] rs2_addr;
        logic [RegW-1:0] rd_addr;
    } register_file_t;

    typedef struct packed {
        logic                alu_sel;
        logic [2:0]          alu_op;
        logic                invert;
        logic                load_sel;
        logic [2:0]          load_op;
        logic                store_sel;
        logic [2:0]          store_op;
        logic                branch_sel;
        logic [2:0]          branch_op;
        op_mux_e             op_mux_sel_0;
        op_mux_e             op_mux_sel_1;
        logic [CoreXlen-1:0] sign_extended;
        register_file_t      addr;
    } core_ctrl_t;

    function automatic int unsigned pend_max(int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register pending-write counters for the decode stage.
// Flags RAW/WAW hazards and latches sb_err on a writeback with nothing pending.
module decode_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned PEND_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RegW-1:0] rs1,
    input  logic [RegW-1:0] rs2,
    input  logic [RegW-1:0] rd,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic            rd_wr,
    input  logic            issue,
    input  logic            wb_valid,
    input  logic [RegW-1:0] wb_rd,
    input  logic            flush_dec,
    input  logic [RegW-1:0] flush_rd,
    output logic            hazard,
    output logic            sb_err
);

    localparam int unsigned CntW = PEND_W + 1;
    localparam logic [PEND_W-1:0] PendMax = PEND_W'(pend_max(PEND_W));

    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];
    logic [PEND_W-1:0] eff    [NUM_REGS];
    logic              err_set;
    logic              sb_err_q;

    always_comb begin
        logic            hit;
        logic            wb_dec;
        logic            fl_dec;
        logic            inc;
        logic [CntW-1:0] up;
        logic [CntW-1:0] down;
        logic [CntW-1:0] diff;
        hit     = 1'b0;
        wb_dec  = 1'b0;
        fl_dec  = 1'b0;
        inc     = 1'b0;
        up      = '0;
        down    = '0;
        diff    = '0;
        err_set = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            hit    = wb_valid && (wb_rd == RegW'(r)) && (r != 0);
            wb_dec = hit && (pend_q[r] != '0);
            fl_dec = flush_dec && (flush_rd == RegW'(r)) && (r != 0);
            inc    = issue && (rd == RegW'(r)) && (r != 0);
            if (hit && (pend_q[r] == '0)) begin
                err_set = 1'b1;
            end
            // Same-cycle retirement is visible to the hazard check.
            eff[r] = pend_q[r] - PEND_W'(wb_dec);
            up     = {1'b0, pend_q[r]} + CntW'(inc);
            down   = CntW'(wb_dec) + CntW'(fl_dec);
            diff   = up - down;
            if (up > down) begin
                pend_d[r] = diff[PEND_W-1:0];
            end else begin
                pend_d[r] = '0;
            end
        end
        pend_d[0] = '0;
        eff[0]    = '0;
    end

    always_comb begin
        hazard = 1'b0;
        if (rs1_used && (rs1 != '0) && (eff[rs1] != '0)) begin
            hazard = 1'b1;
        end
        if (rs2_used && (rs2 != '0) && (eff[rs2] != '0)) begin
            hazard = 1'b1;
        end
        if (rd_wr && (rd != '0) && (eff[rd] == PendMax)) begin
            hazard = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '{default: '0};
            sb_err_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (err_set) begin
                sb_err_q <= 1'b1;
            end
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: cracks fetch instructions into core_ctrl_t behind a one-entry output register.
// Define DECODE_ILLEGAL_EN to add the registered out_illegal flag.
module decode_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned PEND_W   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_inst,
    input  logic [XLEN-1:0]               in_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$bits(core_ctrl_t)-1:0] out_ctrl,
    output logic [XLEN-1:0]               out_pc,
    input  logic                          wb_valid,
    input  logic [4:0]                    wb_rd,
    input  logic                          flush,
`ifdef DECODE_ILLEGAL_EN
    output logic                          out_illegal,
`endif
    output logic                          sb_err
);

    core_ctrl_t ctrl;
    imm_sel_t   imm_sel;
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_wr;
    logic       illegal;
    logic       rd_zero;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic       hazard;
    logic       in_fire;
    logic       out_fire;
    logic       issue;

    core_ctrl_t      ctrl_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            held_wr_q;
`ifdef DECODE_ILLEGAL_EN
    logic            illegal_q;
`endif

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    always_comb begin
        ctrl     = '0;
        imm_sel  = IMM_NONE;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        rd_wr    = 1'b0;
        illegal  = 1'b0;
        rd_zero  = 1'b0;
        unique case (opcode)
            OP: begin
                ctrl.alu_sel = 1'b1;
                ctrl.alu_op  = funct3;
                ctrl.invert  = in_inst[30];
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                rd_wr        = 1'b1;
                if (funct7 == 7'b0100000) begin
                    illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                end else if (funct7 != 7'b0000000) begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                ctrl.alu_sel      = 1'b1;
                ctrl.alu_op       = funct3;
                ctrl.invert       = (funct3 == 3'b101) && in_inst[30];
                ctrl.op_mux_sel_1 = IMEM;
                imm_sel           = IMM_I;
                rs1_used          = 1'b1;
                rd_wr             = 1'b1;
            end
            LOAD: begin
                ctrl.load_sel     = 1'b1;
                ctrl.load_op      = funct3;
                ctrl.op_mux_sel_1 = IMEM;
                imm_sel           = IMM_I;
                rs1_used          = 1'b1;
                rd_wr             = 1'b1;
                illegal           = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            STORE: begin
                ctrl.store_sel    = 1'b1;
                ctrl.store_op     = funct3;
                ctrl.op_mux_sel_1 = IMEM;
                imm_sel           = IMM_S;
                rs1_used          = 1'b1;
                rs2_used          = 1'b1;
                rd_zero           = 1'b1;
                illegal           = (funct3 >= 3'b011);
            end
            BRANCH: begin
                ctrl.branch_sel = 1'b1;
                ctrl.branch_op  = funct3;
                imm_sel         = IMM_B;
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
                rd_zero         = 1'b1;
                illegal         = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            default: illegal = 1'b1;
        endcase

        unique case (imm_sel)
            IMM_I:   ctrl.sign_extended = {{20{in_inst[31]}}, in_inst[31:20]};
            IMM_S:   ctrl.sign_extended = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            IMM_B:   ctrl.sign_extended = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25],
                                           in_inst[11:8], 1'b0};
            default: ctrl.sign_extended = '0;
        endcase

        ctrl.addr.rs1_addr = in_inst[19:15];
        ctrl.addr.rs2_addr = in_inst[24:20];
        ctrl.addr.rd_addr  = rd_zero ? 5'd0 : in_inst[11:7];

        // Illegal encodings never stall and never reserve a destination.
        if (illegal) begin
`ifdef DECODE_ILLEGAL_EN
            ctrl      = '{addr: ctrl.addr, default: '0};
`else
            ctrl      = '0;
`endif
            rs1_used = 1'b0;
            rs2_used = 1'b0;
            rd_wr    = 1'b0;
        end
    end

    decode_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .PEND_W   (PEND_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rs1       (ctrl.addr.rs1_addr),
        .rs2       (ctrl.addr.rs2_addr),
        .rd        (ctrl.addr.rd_addr),
        .rs1_used  (rs1_used),
        .rs2_used  (rs2_used),
        .rd_wr     (rd_wr),
        .issue     (issue),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush_dec (flush && valid_q && held_wr_q),
        .flush_rd  (ctrl_q.addr.rd_addr),
        .hazard    (hazard),
        .sb_err    (sb_err)
    );

    assign in_ready = !hazard && !flush && (!valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;
    assign issue    = in_fire && rd_wr && (ctrl.addr.rd_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc_q      <= '0;
            held_wr_q <= 1'b0;
`ifdef DECODE_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_fire) begin
            valid_q   <= 1'b1;
            ctrl_q    <= ctrl;
            pc_q      <= in_pc;
            held_wr_q <= rd_wr && (ctrl.addr.rd_addr != 5'd0);
`ifdef DECODE_ILLEGAL_EN
            illegal_q <= illegal;
`endif
        end else if (out_fire) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_pc    = pc_q;
`ifdef DECODE_ILLEGAL_EN
    assign out_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized bench for decode_stage against a behavioural decode/scoreboard model.
module tb_decode_stage;
    import core_pkg::*;

    localparam int XLEN = 32;
    localparam int PMAX = 3;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          in_valid;
    logic                          in_ready;
    logic [31:0]                   in_inst;
    logic [XLEN-1:0]               in_pc;
    logic                          out_valid;
    logic                          out_ready;
    logic [$bits(core_ctrl_t)-1:0] out_ctrl;
    logic [XLEN-1:0]               out_pc;
    logic                          wb_valid;
    logic [4:0]                    wb_rd;
    logic                          flush;
    logic                          sb_err;
`ifdef DECODE_ILLEGAL_EN
    logic                          out_illegal;
`endif

    always #5 clk = ~clk;

    decode_stage #(
        .XLEN     (XLEN),
        .NUM_REGS (32),
        .PEND_W   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_pc    (out_pc),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
`ifdef DECODE_ILLEGAL_EN
        .out_illegal (out_illegal),
`endif
        .sb_err    (sb_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model state
    int         pend [32];
    bit         m_ov;
    core_ctrl_t m_ctrl;
    logic [31:0] m_pc;
    bit         m_err;
    bit         m_held_wr;
    bit         m_ill;

    typedef struct {
        core_ctrl_t c;
        bit         u1;
        bit         u2;
        bit         wr;
        bit         ill;
    } dec_t;

    function automatic int sext12(input logic [11:0] v);
        int x;
        x = int'(v);
        if (x >= 2048) x -= 4096;
        return x;
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        int imm;
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        d.c = '0;
        d.u1 = 0; d.u2 = 0; d.wr = 0; d.ill = 0;
        imm = 0;
        d.c.addr.rs1_addr = i[19:15];
        d.c.addr.rs2_addr = i[24:20];
        d.c.addr.rd_addr  = i[11:7];
        case (opc)
            7'b0110011: begin
                d.c.alu_sel = 1; d.c.alu_op = f3; d.c.invert = i[30];
                d.u1 = 1; d.u2 = 1; d.wr = 1;
                if (!(f7 inside {7'h00, 7'h20})) d.ill = 1;
                if (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})) d.ill = 1;
            end
            7'b0010011: begin
                d.c.alu_sel = 1; d.c.alu_op = f3; d.c.invert = (f3 == 3'd5) ? i[30] : 1'b0;
                d.c.op_mux_sel_1 = IMEM; imm = sext12(i[31:20]);
                d.u1 = 1; d.wr = 1;
            end
            7'b0000011: begin
                d.c.load_sel = 1; d.c.load_op = f3; d.c.op_mux_sel_1 = IMEM;
                imm = sext12(i[31:20]); d.u1 = 1; d.wr = 1;
                d.ill = f3 inside {3'd3, 3'd6, 3'd7};
            end
            7'b0100011: begin
                d.c.store_sel = 1; d.c.store_op = f3; d.c.op_mux_sel_1 = IMEM;
                imm = sext12({i[31:25], i[11:7]}); d.u1 = 1; d.u2 = 1;
                d.c.addr.rd_addr = 0;
                d.ill = (f3 >= 3);
            end
            7'b1100011: begin
                d.c.branch_sel = 1; d.c.branch_op = f3;
                imm = 2 * sext12({i[31], i[7], i[30:25], i[11:8]});
                d.u1 = 1; d.u2 = 1;
                d.c.addr.rd_addr = 0;
                d.ill = f3 inside {3'd2, 3'd3};
            end
            default: d.ill = 1;
        endcase
        d.c.sign_extended = imm;
        if (d.ill) begin
`ifdef DECODE_ILLEGAL_EN
            d.c = '{addr: d.c.addr, default: '0};
`else
            d.c = '0;
`endif
            d.u1 = 0; d.u2 = 0; d.wr = 0;
        end
        return d;
    endfunction

    function automatic int eff_pend(input int r);
        if (r == 0) return 0;
        if (wb_valid && int'(wb_rd) == r && pend[r] > 0) return pend[r] - 1;
        return pend[r];
    endfunction

    function automatic bit ref_hazard(input dec_t d);
        bit h;
        h = 0;
        if (d.u1 && eff_pend(int'(d.c.addr.rs1_addr)) != 0) h = 1;
        if (d.u2 && eff_pend(int'(d.c.addr.rs2_addr)) != 0) h = 1;
        if (d.wr && d.c.addr.rd_addr != 0 && eff_pend(int'(d.c.addr.rd_addr)) == PMAX) h = 1;
        return h;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) pend[r] = 0;
        m_ov = 0; m_ctrl = '0; m_pc = '0; m_err = 0; m_held_wr = 0; m_ill = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_ov);
        check("sb_err", sb_err, m_err);
        if (m_ov) begin
            check("out_ctrl", out_ctrl, m_ctrl);
            check("out_pc", out_pc, m_pc);
`ifdef DECODE_ILLEGAL_EN
            check("out_illegal", out_illegal, m_ill);
`endif
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        dec_t d;
        bit   exp_rdy;
        bit   fire;
        bit   ofire;
        #1;
        d       = ref_decode(in_inst);
        exp_rdy = !ref_hazard(d) && !flush && (!m_ov || out_ready);
        check("in_ready", in_ready, exp_rdy);
        fire  = in_valid && exp_rdy;
        ofire = m_ov && out_ready && !flush;
        for (int r = 1; r < 32; r++) begin
            int down;
            int nv;
            down = 0;
            if (wb_valid && int'(wb_rd) == r) begin
                if (pend[r] > 0) down++;
                else m_err = 1;
            end
            if (flush && m_ov && m_held_wr && int'(m_ctrl.addr.rd_addr) == r) down++;
            nv = pend[r] + ((fire && d.wr && int'(d.c.addr.rd_addr) == r) ? 1 : 0) - down;
            pend[r] = (nv < 0) ? 0 : nv;
        end
        if (flush) begin
            m_ov = 0;
        end else if (fire) begin
            m_ov = 1; m_ctrl = d.c; m_pc = in_pc; m_ill = d.ill;
            m_held_wr = d.wr && (d.c.addr.rd_addr != 0);
        end else if (ofire) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                         input bit ordy, input bit wbv, input int wbr, input bit fl);
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        wb_valid  = wbv;
        wb_rd     = 5'(wbr);
        flush     = fl;
        tick();
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; in_inst = '0; in_pc = '0; out_ready = 0;
        wb_valid = 0; wb_rd = '0; flush = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_ctrl", out_ctrl, '0);
        check("rst out_pc", out_pc, '0);
        check("rst sb_err", sb_err, 1'b0);
        @(negedge clk);
        rst = 0;
    endtask

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0]  r1, r2, rdx;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] im;
        r1  = 5'($urandom_range(0, 7));
        r2  = 5'($urandom_range(0, 7));
        rdx = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        im  = 12'($urandom);
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0:       return {f7, r2, r1, f3, rdx, 7'b0110011};
            1:       return {im, r1, f3, rdx, 7'b0010011};
            2:       return {im, r1, f3, rdx, 7'b0000011};
            3:       return {im[11:5], r2, r1, f3, im[4:0], 7'b0100011};
            4:       return {im[11:5], r2, r1, f3, im[4:0], 7'b1100011};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        do_reset();

        // Back-to-back independent ADDIs, then a reader of x1/x2 must stall
        for (int k = 1; k <= 4; k++) drive(1, addi(k, 0, k * 3 - 5), 32'h100 + 4 * k, 1, 0, 0, 0);
        drive(0, add(5, 1, 2), 32'h0, 1, 0, 0, 0);

        // RAW stall released by same-cycle writeback
        do_reset();
        drive(1, addi(1, 0, 7), 32'h200, 1, 0, 0, 0);
        drive(1, add(5, 1, 2), 32'h204, 1, 0, 0, 0);
        drive(1, add(5, 1, 2), 32'h204, 1, 1, 1, 0);
        drive(0, 32'h0, 32'h0, 1, 0, 0, 0);

        // Counter saturation on x7
        do_reset();
        for (int k = 0; k < 3; k++) drive(1, lw(7, 0, k), 32'h300 + 4 * k, 1, 0, 0, 0);
        drive(1, lw(7, 0, 3), 32'h30c, 1, 0, 0, 0);
        drive(1, lw(7, 0, 3), 32'h30c, 1, 1, 7, 0);
        drive(1, lw(7, 0, 4), 32'h310, 1, 0, 0, 0);

        // Issue and retire x9 together, then error on an idle register
        do_reset();
        drive(1, addi(9, 0, 1), 32'h400, 1, 0, 0, 0);
        drive(1, addi(9, 0, 2), 32'h404, 1, 1, 9, 0);
        drive(0, 32'h0, 32'h0, 1, 1, 9, 0);
        drive(0, 32'h0, 32'h0, 1, 1, 10, 0);
        drive(0, 32'h0, 32'h0, 1, 0, 0, 0);
        drive(0, 32'h0, 32'h0, 1, 0, 0, 0);

        // Flush of a held writer returns its reservation
        do_reset();
        drive(1, addi(3, 0, 5), 32'h500, 0, 0, 0, 0);
        drive(1, addi(4, 0, 6), 32'h504, 0, 0, 0, 1);
        drive(1, add(5, 3, 3), 32'h508, 1, 0, 0, 0);

        // Illegal opcodes, one with a nonzero rd field
        do_reset();
        drive(1, 32'h0000007F, 32'h600, 1, 0, 0, 0);
        drive(1, 32'h000000FF, 32'h604, 1, 0, 0, 0);
        drive(1, add(2, 1, 1), 32'h608, 1, 0, 0, 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int  wr;
            bit  wv;
            bit  fl;
            bit  ordy;
            wv = 0;
            wr = 0;
            if ($urandom_range(0, 9) < 4) begin
                int cand [$];
                for (int r = 1; r < 8; r++) if (pend[r] > 0) cand.push_back(r);
                if (cand.size() > 0) begin
                    wv = 1;
                    wr = cand[$urandom_range(0, cand.size() - 1)];
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            fl   = m_ov && ($urandom_range(0, 19) == 0);
            if (fl) ordy = 0;
            drive($urandom_range(0, 3) != 0, rand_inst(), $urandom, ordy, wv, wr, fl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
